// File: rtl/rf_multiport_pkg.sv
// Shared types and default geometry for the multi-port register file.
package rf_multiport_pkg;

  // Clear-engine / run state encoding
  typedef enum logic {
    RF_ST_CLR = 1'b0,
    RF_ST_RUN = 1'b1
  } rf_state_e;

  localparam int unsigned RF_DW  = 32;
  localparam int unsigned RF_AW  = 5;
  localparam int unsigned RF_NRD = 2;

  // Extra stored bit per entry when parity is built in
`ifdef RF_PARITY_EN
  localparam int unsigned RF_PAR_W = 1;
`else
  localparam int unsigned RF_PAR_W = 0;
`endif

endpackage

// File: rtl/rf_multiport_if.sv
// Register-file access bus: write request, read addresses and read results.
interface rf_multiport_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
);
  logic              pause;
  logic              rd_clk_cls;
  logic              wren;
  logic [AW-1:0]     wraddress;
  logic [DW-1:0]     data;
  logic [NRD*AW-1:0] rdaddress;
  logic [NRD*DW-1:0] q;
  logic              init_busy;
  logic [NRD-1:0]    parity_err;

  modport master (
    output pause, rd_clk_cls, wren, wraddress, data, rdaddress,
    input  q, init_busy, parity_err
  );

  modport slave (
    input  pause, rd_clk_cls, wren, wraddress, data, rdaddress,
    output q, init_busy, parity_err
  );
endinterface

// File: rtl/rf_read_port.sv
// One read port: registered address plus zero / bypass / bank select and parity check.
module rf_read_port
  import rf_multiport_pkg::*;
#(
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned BW       = RF_DW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          cap_en,
  input  logic [AW-1:0] rdaddress,
  input  logic          run,
  input  logic          r_wren,
  input  logic [AW-1:0] r_wraddress,
  input  logic [DW-1:0] r_data,
  input  logic [BW-1:0] bank_word,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] q,
  output logic          parity_err
);

  logic zero_hit_c;
  logic byp_hit_c;

  // Read address capture
  always_ff @(posedge clock or posedge rst) begin
    if (rst)         addr <= '0;
    else if (cap_en) addr <= rdaddress;
  end

  // Priority select: hard zero, then in-flight write, then stored entry
  always_comb begin
    zero_hit_c = (ZERO_REG != 0) && (addr == '0);
    byp_hit_c  = r_wren && (r_wraddress == addr);
    q          = '0;
    parity_err = 1'b0;
    if (run && !zero_hit_c) begin
      if (byp_hit_c) begin
        q = r_data;
      end else begin
        q = bank_word[DW-1:0];
`ifdef RF_PARITY_EN
        parity_err = ^bank_word;
`endif
      end
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multi-read-port register file with registered write stage, bypass and
// post-reset clear engine. Optional parity via `RF_PARITY_EN.
module rf_multiport
  import rf_multiport_pkg::*;
#(
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned NRD      = RF_NRD,
  parameter int unsigned ZERO_REG = 1
) (
  input logic          clock,
  input logic          rst,
  rf_multiport_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned BW    = DW + RF_PAR_W;

  rf_state_e     state;
  rf_state_e     state_nxt;
  logic [AW-1:0] clr_ptr;
  logic          run_c;
  logic          commit_c;
  logic          rd_cap_c;
  logic [BW-1:0] wr_word_c;

  logic          r_wren;
  logic [AW-1:0] r_wraddress;
  logic [DW-1:0] r_data;

  logic [BW-1:0]     bank [DEPTH];
  logic [AW-1:0]     rd_addr [NRD];
  logic [NRD*DW-1:0] q_w;
  logic [NRD-1:0]    perr_w;

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= RF_ST_CLR;
    else     state <= state_nxt;
  end

  // Next state: leave CLR once the last entry has been cleared
  always_comb begin
    state_nxt = state;
    if (state == RF_ST_CLR && clr_ptr == AW'(DEPTH - 1)) state_nxt = RF_ST_RUN;
  end

  // State decode outputs
  always_comb begin
    run_c         = (state == RF_ST_RUN);
    bus.init_busy = (state == RF_ST_CLR);
  end

  // Clear pointer walks the bank once per reset
  always_ff @(posedge clock or posedge rst) begin
    if (rst)         clr_ptr <= '0;
    else if (!run_c) clr_ptr <= clr_ptr + AW'(1);
  end

  // Write stage capture; requests are dropped while clearing
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wren      <= 1'b0;
      r_wraddress <= '0;
      r_data      <= '0;
    end else if (!run_c) begin
      r_wren      <= 1'b0;
    end else if (!bus.pause) begin
      r_wren      <= bus.wren;
      r_wraddress <= bus.wraddress;
      r_data      <= bus.data;
    end
  end

  // Commit qualification and stored word
  always_comb begin
    commit_c = run_c && r_wren && !((ZERO_REG != 0) && (r_wraddress == '0));
    rd_cap_c = run_c && !bus.pause && !bus.rd_clk_cls;
`ifdef RF_PARITY_EN
    wr_word_c = {^r_data, r_data};
`else
    wr_word_c = r_data;
`endif
  end

  // Bank write: clear engine owns the port until RUN
  always_ff @(posedge clock) begin
    if (!run_c)        bank[clr_ptr]     <= '0;
    else if (commit_c) bank[r_wraddress] <= wr_word_c;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(
      .DW(DW), .AW(AW), .BW(BW), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clock      (clock),
      .rst        (rst),
      .cap_en     (rd_cap_c),
      .rdaddress  (bus.rdaddress[i*AW +: AW]),
      .run        (run_c),
      .r_wren     (r_wren),
      .r_wraddress(r_wraddress),
      .r_data     (r_data),
      .bank_word  (bank[rd_addr[i]]),
      .addr       (rd_addr[i]),
      .q          (q_w[i*DW +: DW]),
      .parity_err (perr_w[i])
    );
  end

  // Drive bus results
  always_comb begin
    bus.q          = q_w;
    bus.parity_err = perr_w;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench: unit A (NRD=2, ZERO_REG=1) and unit B (NRD=4, ZERO_REG=0).
module tb_rf_multiport;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  rf_multiport_if #(.DW(32), .AW(5), .NRD(2)) ifa ();
  rf_multiport_if #(.DW(32), .AW(5), .NRD(4)) ifb ();

  rf_multiport #(.DW(32), .AW(5), .NRD(2), .ZERO_REG(1)) dut_a (
    .clock(clock), .rst(rst), .bus(ifa)
  );
  rf_multiport #(.DW(32), .AW(5), .NRD(4), .ZERO_REG(0)) dut_b (
    .clock(clock), .rst(rst), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_a(input logic [4:0] p0, input logic [4:0] p1);
    ifa.rdaddress = {p1, p0};
  endtask

  // Count cycles until init_busy falls, with a cycle budget
  task automatic wait_clr(input string tag);
    int cnt;
    cnt = 0;
    while (ifa.init_busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      if (cnt == 10) ifa.wren = 1'b0;
    end
    check(tag, 32'(cnt), 32'd32);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1);
  end

  initial begin
    ifa.pause = 0; ifa.rd_clk_cls = 0; ifa.wren = 0; ifa.wraddress = '0;
    ifa.data = '0; ifa.rdaddress = '0;
    ifb.pause = 0; ifb.rd_clk_cls = 0; ifb.wren = 0; ifb.wraddress = '0;
    ifb.data = '0; ifb.rdaddress = '0;

    // Reset state
    #1 rst = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(ifa.init_busy), 32'd1);
    check("rst_q0", ifa.q[31:0], 32'd0);
    check("rst_q1", ifa.q[63:32], 32'd0);
    check("rst_perr", 32'(ifa.parity_err), 32'd0);

    // Clear engine length; writes attempted during clear must vanish
    ifa.wren = 1'b1; ifa.wraddress = 5'd5; ifa.data = 32'hFFFF_FFFF;
    rst = 1'b0;
    wait_clr("clr_len");
    check("clr_busy_b", 32'(ifb.init_busy), 32'd0);
    for (int a = 0; a < 32; a++) begin
      rd_a(5'(a), 5'(31 - a));
      tick();
      check($sformatf("clr_rd0_%0d", a), ifa.q[31:0], 32'd0);
      check($sformatf("clr_rd1_%0d", a), ifa.q[63:32], 32'd0);
    end

    // Write R5 with same-edge read: bypass then bank
    ifa.wren = 1; ifa.wraddress = 5'd5; ifa.data = 32'hDEAD_BEEF; rd_a(5'd5, 5'd6);
    tick();
    check("byp_r5", ifa.q[31:0], 32'hDEAD_BEEF);
    check("byp_r6", ifa.q[63:32], 32'd0);
    ifa.wren = 0;
    tick();
    check("bank_r5", ifa.q[31:0], 32'hDEAD_BEEF);
    check("perr_r5", 32'(ifa.parity_err), 32'd0);

    // Highest address
    ifa.wren = 1; ifa.wraddress = 5'd31; ifa.data = 32'hCAFE_0031; rd_a(5'd5, 5'd31);
    tick();
    ifa.wren = 0;
    tick();
    check("bank_r31", ifa.q[63:32], 32'hCAFE_0031);

    // Entry 0: hard zero on A, ordinary register on B
    ifa.wren = 1; ifa.wraddress = 5'd0; ifa.data = 32'h1234_5678; rd_a(5'd0, 5'd0);
    ifb.wren = 1; ifb.wraddress = 5'd0; ifb.data = 32'h1234_5678; ifb.rdaddress = '0;
    tick();
    check("zero_byp_a", ifa.q[31:0], 32'd0);
    check("r0_byp_b", ifb.q[31:0], 32'h1234_5678);
    ifa.wren = 0; ifb.wren = 0;
    tick();
    check("zero_bank_a", ifa.q[31:0], 32'd0);
    check("r0_bank_b", ifb.q[31:0], 32'h1234_5678);

    // Pause freezes write stage and address capture
    ifa.wren = 1; ifa.wraddress = 5'd7; ifa.data = 32'h11; rd_a(5'd7, 5'd5);
    tick();
    ifa.wren = 0;
    tick();
    check("r7_old", ifa.q[31:0], 32'h11);
    ifa.pause = 1; ifa.wren = 1; ifa.wraddress = 5'd7; ifa.data = 32'hAA; rd_a(5'd5, 5'd7);
    tick();
    check("pause_q0", ifa.q[31:0], 32'h11);
    check("pause_q1", ifa.q[63:32], 32'hDEAD_BEEF);
    tick();
    check("pause_q0_2", ifa.q[31:0], 32'h11);
    ifa.pause = 0; rd_a(5'd7, 5'd7);
    tick();
    check("unpause_byp", ifa.q[31:0], 32'hAA);
    ifa.wren = 0;
    tick();
    check("unpause_bank", ifa.q[63:32], 32'hAA);

    // rd_clk_cls holds read addresses
    ifa.rd_clk_cls = 1; rd_a(5'd5, 5'd31);
    tick();
    check("cls_hold0", ifa.q[31:0], 32'hAA);
    check("cls_hold1", ifa.q[63:32], 32'hAA);
    ifa.rd_clk_cls = 0;
    tick();
    check("cls_rel0", ifa.q[31:0], 32'hDEAD_BEEF);
    check("cls_rel1", ifa.q[63:32], 32'hCAFE_0031);

    // Four ports on the same address as a write
    ifb.wren = 1; ifb.wraddress = 5'd9; ifb.data = 32'h55; ifb.rdaddress = {4{5'd9}};
    tick();
    for (int p = 0; p < 4; p++) check($sformatf("p4_byp_%0d", p), ifb.q[p*32 +: 32], 32'h55);
    ifb.wren = 0;
    tick();
    for (int p = 0; p < 4; p++) check($sformatf("p4_bank_%0d", p), ifb.q[p*32 +: 32], 32'h55);
    ifb.rdaddress = {5'd9, 5'd0, 5'd9, 5'd1};
    tick();
    check("p4_mix0", ifb.q[31:0], 32'd0);
    check("p4_mix1", ifb.q[63:32], 32'h55);
    check("p4_mix2", ifb.q[95:64], 32'h1234_5678);

`ifdef RF_PARITY_EN
    // Corrupt a stored bit: bank read flags, bypass does not
    dut_a.bank[3] = dut_a.bank[3] ^ 33'd1;
    rd_a(5'd3, 5'd4);
    tick();
    check("par_flag", 32'(ifa.parity_err), 32'd1);
    check("par_q0", ifa.q[31:0], 32'd1);
    ifa.wren = 1; ifa.wraddress = 5'd3; ifa.data = 32'hF0;
    tick();
    check("par_byp", 32'(ifa.parity_err), 32'd0);
    ifa.wren = 0;
    tick();
    check("par_fresh", 32'(ifa.parity_err), 32'd0);
`endif

    // Reset during RUN with a pending write
    ifa.wren = 1; ifa.wraddress = 5'd12; ifa.data = 32'h77; rd_a(5'd12, 5'd5);
    tick();
    check("pend_byp", ifa.q[31:0], 32'h77);
    ifa.wren = 0;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(ifa.init_busy), 32'd1);
    check("mid_rst_q0", ifa.q[31:0], 32'd0);
    tick();
    rst = 1'b0;
    wait_clr("clr_len2");
    rd_a(5'd12, 5'd5);
    tick();
    check("post_rst_r12", ifa.q[31:0], 32'd0);
    check("post_rst_r5", ifa.q[63:32], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
